perm_unload: RTL and testbench



---
 rtl/perm_unload.sv | 125 ++++++++++++
 tb/tb_perm_unload.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/perm_unload.sv
// Keccak state unloader: scans the 5x5 lane memory and streams 25 lanes
// out over the push/stop lane protocol, honouring stopout backpressure.
module perm_unload #(
  parameter int unsigned W     = 64,
  parameter int unsigned ORDER = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [2:0]   mrx,
  output logic [2:0]   mry,
  input  logic [W-1:0] mrd,
  output logic         pushout,
  input  logic         stopout,
  output logic         firstout,
  output logic [W-1:0] dout
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state, state_nx;
  logic [2:0]  x, y;
  logic [2:0]  x_nx, y_nx;
  logic [4:0]  cnt;
  logic        may_load;
  logic        last_load;

  assign may_load  = !pushout || !stopout;
  assign last_load = (cnt == 5'd24);

  // Scan-order step; the (4,4) overflow value is never stored, last_load forces (0,0).
  always_comb begin
    x_nx = x;
    y_nx = y;
    if (ORDER == 0) begin
      if (x == 3'd4) begin
        x_nx = '0;
        y_nx = y + 3'd1;
      end else begin
        x_nx = x + 3'd1;
      end
    end else begin
      if (y == 3'd4) begin
        y_nx = '0;
        x_nx = x + 3'd1;
      end else begin
        y_nx = y + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (may_load && last_load) state_nx = DRAIN;
      DRAIN:   if (pushout && !stopout) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    mrx  = x;
    mry  = y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pushout  <= 1'b0;
      firstout <= 1'b0;
      dout     <= '0;
      done     <= 1'b0;
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dout     <= mrd;
            firstout <= 1'b1;
            pushout  <= 1'b1;
            cnt      <= 5'd1;
            x        <= x_nx;
            y        <= y_nx;
          end
        end
        RUN: begin
          if (may_load) begin
            dout     <= mrd;
            firstout <= 1'b0;
            pushout  <= 1'b1;
            cnt      <= cnt + 5'd1;
            if (last_load) begin
              x <= '0;
              y <= '0;
            end else begin
              x <= x_nx;
              y <= y_nx;
            end
          end
        end
        DRAIN: begin
          if (pushout && !stopout) begin
            pushout  <= 1'b0;
            firstout <= 1'b0;
            done     <= 1'b1;
            cnt      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_perm_unload.sv
// Bench for perm_unload: both scan orders run side by side on shared stimulus,
// checked against a lane-index model of the expected stream.
module tb_perm_unload;

  logic        clk = 1'b0;
  logic        rst, start, stopout;
  logic        busy0, done0, push0, first0;
  logic        busy1, done1, push1, first1;
  logic [2:0]  mrx0, mry0, mrx1, mry1;
  logic [63:0] mrd0, mrd1, dout0, dout1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  perm_unload #(.W(64), .ORDER(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
    .mrx(mrx0), .mry(mry0), .mrd(mrd0), .pushout(push0), .stopout(stopout),
    .firstout(first0), .dout(dout0));

  perm_unload #(.W(64), .ORDER(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
    .mrx(mrx1), .mry(mry1), .mrd(mrd1), .pushout(push1), .stopout(stopout),
    .firstout(first1), .dout(dout1));

  function automatic logic [63:0] lane(input int lx, input int ly);
    return {8'(ly), 56'(lx)};
  endfunction

  // Out-of-range reads return a poison value so a bad index shows up in dout.
  always_comb begin
    mrd0 = (mrx0 < 3'd5 && mry0 < 3'd5) ? lane(int'(mrx0), int'(mry0)) : 64'hDEAD_BEEF_DEAD_BEEF;
    mrd1 = (mrx1 < 3'd5 && mry1 < 3'd5) ? lane(int'(mrx1), int'(mry1)) : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_lane(input int k, input string tag);
    chk($sformatf("%s push0 k%0d", tag, k), 64'(push0), 64'd1);
    chk($sformatf("%s push1 k%0d", tag, k), 64'(push1), 64'd1);
    chk($sformatf("%s first0 k%0d", tag, k), 64'(first0), 64'(k == 0));
    chk($sformatf("%s first1 k%0d", tag, k), 64'(first1), 64'(k == 0));
    chk($sformatf("%s dout0 k%0d", tag, k), dout0, lane(k % 5, k / 5));
    chk($sformatf("%s dout1 k%0d", tag, k), dout1, lane(k / 5, k % 5));
    chk($sformatf("%s busy0 k%0d", tag, k), 64'(busy0), 64'd1);
    chk($sformatf("%s done0 k%0d", tag, k), 64'(done0 | done1), 64'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " push"},  64'(push0 | push1), 64'd0);
    chk({tag, " first"}, 64'(first0 | first1), 64'd0);
    chk({tag, " busy"},  64'(busy0 | busy1), 64'd0);
    chk({tag, " addr"},  64'({mrx0, mry0, mrx1, mry1}), 64'd0);
  endtask

  typedef struct {
    int stall0;      // stopout cycles on lane 0
    int stall_lane;  // lane index for an extra stall (-1 none)
    int stall_len;
    bit restart;     // pulse start mid-run and in DRAIN
    int exp_cyc;     // cycle after start in which done is high
  } scen_t;

  // Runs one unload from IDLE; start is sampled at the first edge.
  task automatic do_unload(input scen_t s, input string tag);
    int  k = 0;
    int  held = 0;
    int  cyc;
    bit  xfer;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (k < 25 && cyc < 200) begin
      chk_lane(k, tag);
      start   = s.restart && (k == 5 || k == 24);
      stopout = (k == 0 && held < s.stall0) || (k == s.stall_lane && held < s.stall_len);
      xfer    = !stopout;
      tick();
      cyc++;
      if (xfer) begin
        k++;
        held = 0;
      end else begin
        held++;
      end
    end
    start   = 1'b0;
    stopout = 1'b0;
    chk({tag, " lanes"},   64'(k), 64'd25);
    chk({tag, " done_cyc"}, 64'(cyc), 64'(s.exp_cyc));
    chk({tag, " done0"},   64'(done0), 64'd1);
    chk({tag, " done1"},   64'(done1), 64'd1);
    chk_idle({tag, " donecyc"});
  endtask

  scen_t tab[4];

  initial begin
    tab[0] = '{stall0: 0, stall_lane: -1, stall_len: 0,  restart: 1'b0, exp_cyc: 26};
    tab[1] = '{stall0: 3, stall_lane: 12, stall_len: 2,  restart: 1'b0, exp_cyc: 31};
    tab[2] = '{stall0: 0, stall_lane: 24, stall_len: 10, restart: 1'b0, exp_cyc: 36};
    tab[3] = '{stall0: 0, stall_lane: -1, stall_len: 0,  restart: 1'b1, exp_cyc: 26};

    rst = 1'b1; start = 1'b0; stopout = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_idle("reset");
    chk("reset dout", dout0 | dout1, 64'd0);
    chk("reset done", 64'(done0 | done1), 64'd0);
    tick();

    for (int i = 0; i < 4; i++) begin
      do_unload(tab[i], $sformatf("scen%0d", i));
      tick();
      chk_idle($sformatf("scen%0d after", i));
      chk($sformatf("scen%0d done clr", i), 64'(done0 | done1), 64'd0);
      chk($sformatf("scen%0d dout kept", i), dout0, lane(4, 4));
    end

    // Back-to-back: second start lands in the done cycle.
    do_unload(tab[0], "b2b_a");
    do_unload(tab[0], "b2b_b");
    tick();

    // Reset while lane 10 is stalled.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    stopout = 1'b1;
    tick();
    chk_lane(10, "rst_stall");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stopout = 1'b0;
    chk_idle("rst_mid");
    chk("rst_mid dout", dout0 | dout1, 64'd0);
    chk("rst_mid done", 64'(done0 | done1), 64'd0);
    tick();
    do_unload(tab[0], "post_rst");
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
